stack_cpu_param: RTL

- Parametrised successor of the 8-bit stack CPU core. Generalises data width, address width and stack depth.
- Adds a req/ack data-memory handshake, stack overflow/underflow detection, DUP/SWAP/HALT opcodes, and a sticky multi-bit error code.
- Sits between the instruction ROM and the data memory/IO bus.

---
 rtl/stack_cpu_param.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/stack_cpu_param.sv
// Parametrised stack CPU core: RUN/MEM/STOP sequencer, DEPTH-entry data stack,
// req/ack data-memory port and a sticky error code.
module stack_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W+3:0]        i_data,
    output logic [ADDR_W-1:0]        d_addr,
    output logic [DATA_W-1:0]        d_wdata,
    input  logic [DATA_W-1:0]        d_rdata,
    output logic                     d_we,
    output logic                     d_req,
    input  logic                     d_ack,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     halted,
    output logic [3:0]               err_code,
    output logic                     error
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(DEPTH);
    localparam logic [SP_W-1:0]   SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0]   SP_TWO  = SP_W'(2);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [3:0] OP_PUSHC = 4'h0;
    localparam logic [3:0] OP_PUSH  = 4'h1;
    localparam logic [3:0] OP_POP   = 4'h2;
    localparam logic [3:0] OP_JUMP  = 4'h3;
    localparam logic [3:0] OP_JZ    = 4'h4;
    localparam logic [3:0] OP_JS    = 4'h5;
    localparam logic [3:0] OP_ADD   = 4'h6;
    localparam logic [3:0] OP_SUB   = 4'h7;
    localparam logic [3:0] OP_DUP   = 4'h8;
    localparam logic [3:0] OP_SWAP  = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;
    logic              r_z;
    logic              r_s;
    logic [3:0]        r_err;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_mwdata;
    logic              r_mwe;
    logic [DATA_W-1:0] r_stack [DEPTH];

    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_operand;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_tos_idx;
    logic [IDX_W-1:0]  w_nos_idx;
    logic [DATA_W-1:0] w_tos;
    logic [DATA_W-1:0] w_nos;
    logic [DATA_W-1:0] w_result;
    logic              w_arith_ovf;
    logic              w_taken;
    logic              w_full;
    logic [3:0]        w_new_err;
    logic              w_fatal;
    logic              w_in_mem;
    logic              w_mem_load;

    assign w_op       = i_data[DATA_W+3:DATA_W];
    assign w_operand  = i_data[DATA_W-1:0];
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_tos_idx  = r_sp[IDX_W-1:0] - IDX_W'(1);
    assign w_nos_idx  = r_sp[IDX_W-1:0] - IDX_W'(2);
    assign w_tos      = r_stack[w_tos_idx];
    assign w_nos      = r_stack[w_nos_idx];
    assign w_full     = (r_sp == SP_FULL);
    assign w_in_mem   = (r_state == ST_MEM);
    assign w_mem_load = w_in_mem && d_ack && !r_mwe;

    // Signed overflow: operands that agree in sign (ADD) or differ (SUB) yet flip NOS's sign.
    assign w_result    = (w_op == OP_SUB) ? (w_nos - w_tos) : (w_nos + w_tos);
    assign w_arith_ovf = (w_result[DATA_W-1] != w_nos[DATA_W-1]) &&
                         ((w_op == OP_SUB) ? (w_nos[DATA_W-1] != w_tos[DATA_W-1])
                                           : (w_nos[DATA_W-1] == w_tos[DATA_W-1]));

    always_comb begin
        w_new_err = 4'b0000;
        w_taken   = 1'b0;
        case (w_op)
            OP_PUSHC, OP_PUSH: w_new_err[1] = w_full;
            OP_DUP: begin
                w_new_err[1] = w_full;
                w_new_err[2] = (r_sp == '0);
            end
            OP_POP, OP_JUMP: w_new_err[2] = (r_sp == '0);
            OP_JZ, OP_JS: begin
                w_taken      = (w_op == OP_JZ) ? r_z : r_s;
                w_new_err[2] = w_taken && (r_sp == '0);
            end
            OP_ADD, OP_SUB: begin
                w_new_err[2] = (r_sp < SP_TWO);
                w_new_err[0] = (r_sp >= SP_TWO) && w_arith_ovf;
            end
            OP_SWAP: w_new_err[2] = (r_sp < SP_TWO);
            OP_HALT: w_new_err = 4'b0000;
            default: w_new_err[3] = 1'b1;
        endcase
    end

    assign w_fatal = |w_new_err[3:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_pc     <= '0;
            r_sp     <= '0;
            r_z      <= 1'b0;
            r_s      <= 1'b0;
            r_err    <= 4'b0000;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_mwe    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_err <= r_err | w_new_err;
                    if (w_fatal) begin
                        r_state <= ST_STOP;
                    end else begin
                        case (w_op)
                            OP_PUSHC, OP_DUP: begin
                                r_sp <= r_sp + SP_ONE;
                                r_pc <= r_pc + PC_ONE;
                            end
                            OP_PUSH, OP_POP: begin
                                r_maddr  <= w_operand[ADDR_W-1:0];
                                r_mwdata <= w_tos;
                                r_mwe    <= (w_op == OP_POP);
                                r_state  <= ST_MEM;
                            end
                            OP_JUMP: begin
                                r_pc <= w_tos[ADDR_W-1:0];
                                r_sp <= r_sp - SP_ONE;
                            end
                            OP_JZ, OP_JS: begin
                                if (w_taken) begin
                                    r_pc <= w_tos[ADDR_W-1:0];
                                    r_sp <= r_sp - SP_ONE;
                                end else begin
                                    r_pc <= r_pc + PC_ONE;
                                end
                            end
                            OP_ADD, OP_SUB: begin
                                r_z  <= (w_result == '0);
                                r_s  <= w_result[DATA_W-1];
                                r_sp <= r_sp - SP_ONE;
                                r_pc <= r_pc + PC_ONE;
                            end
                            OP_SWAP: r_pc <= r_pc + PC_ONE;
                            default: r_state <= ST_STOP;
                        endcase
                    end
                end
                ST_MEM: begin
                    if (d_ack) begin
                        r_sp    <= r_mwe ? (r_sp - SP_ONE) : (r_sp + SP_ONE);
                        r_pc    <= r_pc + PC_ONE;
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_STOP;
            endcase
        end
    end

    // Stack contents carry no reset; only the occupancy count decides what is valid.
    always_ff @(posedge clk) begin
        if (r_state == ST_RUN && !w_fatal) begin
            case (w_op)
                OP_PUSHC:       r_stack[w_push_idx] <= w_operand;
                OP_DUP:         r_stack[w_push_idx] <= w_tos;
                OP_ADD, OP_SUB: r_stack[w_nos_idx]  <= w_result;
                OP_SWAP: begin
                    r_stack[w_nos_idx] <= w_tos;
                    r_stack[w_tos_idx] <= w_nos;
                end
                default: ;
            endcase
        end else if (w_mem_load) begin
            r_stack[w_push_idx] <= d_rdata;
        end
    end

    assign i_addr   = r_pc;
    assign d_addr   = r_maddr;
    assign d_wdata  = r_mwdata;
    assign d_req    = w_in_mem;
    assign d_we     = w_in_mem && r_mwe;
    assign sp       = r_sp;
    assign halted   = (r_state == ST_STOP);
    assign err_code = r_err;
    assign error    = |r_err;

endmodule
